// File: rtl/instr_loader.sv
// Boot-time program loader: length-prefixed byte stream into byte-addressed instruction memory.
// Optional trailing XOR checksum byte is enabled by defining INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  // Largest legal image length; compared one bit wider so the shift cannot wrap.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [1:0]            len_cnt_q, len_cnt_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic                  accept;
  logic [31:0]           len_new;
  logic [ADDR_WIDTH:0]   idx_inc;

  assign accept  = in_valid && in_ready;
  assign len_new = {in_data, len_q[31:8]};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (start) begin
      // Abort wins over any byte handshaked in the same cycle.
      state_d   = S_LEN;
      len_d     = '0;
      len_cnt_d = '0;
      idx_d     = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else if (accept) begin
      case (state_q)
        S_LEN: begin
          len_d     = len_new;
          len_cnt_d = len_cnt_q + 1'b1;
          if (len_cnt_q == 2'd3) begin
            if ({1'b0, len_new} > CAPACITY) begin
              state_d = S_ERR;
            end else if (len_new == '0) begin
              state_d = S_AFTER_DATA;
            end else begin
              state_d = S_DATA;
              idx_d   = '0;
            end
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_WIDTH-1:0];
          wr_data_d = in_data;
          idx_d     = idx_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          // Length fits in ADDR_WIDTH+1 bits once past the overflow check.
          if (idx_inc == len_q[ADDR_WIDTH:0]) begin
            state_d = S_AFTER_DATA;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CSUM: begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LEN;
      len_q     <= '0;
      len_cnt_q <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      len_cnt_q <= len_cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign busy     = in_ready;
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed test-plan images plus randomized images
// checked against a stream-level model (expected writes = payload list, outcome from length/checksum).
module tb_instr_loader;
  localparam int AW  = 10;
  localparam int CAP = 1 << AW;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          err;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] wq[$];
  logic [7:0]  tx[$];
  logic [7:0]  pay[$];
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;
  int          both_cnt = 0;

  // Observe the memory-write port and flag timing on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en === 1'b1) begin
      wq.push_back(32'({wr_addr, wr_data}));
      last_wr_cyc <= cyc;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc <= cyc;
    done_prev <= done;
    if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall: 0 back-to-back, 1 valid toggles every cycle, 2 random gaps
  task automatic send_stream(input int stall);
    foreach (tx[i]) begin
      if (i > 0 && stall == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end else if (stall == 2) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = tx[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic rearm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic random_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  // Build the stream for length n from pay, run it, then compare against the model.
  task automatic run_image(input string tag, input logic [31:0] n, input bit bad, input int stall);
    logic [7:0] x;
    bit         ok;
    int         nw;
    x = 8'h00;
    tx.delete();
    tx.push_back(n[7:0]);
    tx.push_back(n[15:8]);
    tx.push_back(n[23:16]);
    tx.push_back(n[31:24]);
    if (n <= 32'(CAP)) begin
      foreach (pay[i]) begin
        tx.push_back(pay[i]);
        x = x ^ pay[i];
      end
      if (CSUM_EN) tx.push_back(bad ? (x ^ 8'h5A) : x);
    end
    tx.push_back(8'($urandom));
    tx.push_back(8'($urandom));
    wq.delete();
    send_stream(stall);
    repeat (3) @(negedge clk);
    ok = (n <= 32'(CAP)) && !(CSUM_EN && bad);
    nw = (n <= 32'(CAP)) ? int'(n) : 0;
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_err"}, 32'(err), 32'(!ok));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_count"}, 32'(wq.size()), 32'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wq[i], 32'((i << 8) | int'(pay[i])));
    $display("txn %s len=%0d stall=%0d bad=%0d writes=%0d done=%0b err=%0b",
             tag, n, stall, bad, wq.size(), done, err);
  endtask

  initial begin
    logic [31:0] n;
    int          sel;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    pay = '{8'h93, 8'h00, 8'h40, 8'h00};
    run_image("prog", 32'd4, 1'b0, 0);
`ifndef INSTR_LOADER_CHECKSUM_EN
    chk("prog_done_with_last_wr", 32'(done_rise_cyc), 32'(last_wr_cyc));
`endif
    chk("prog_wr_hold_addr", 32'(wr_addr), 32'd3);

    // Asynchronous reset must act without a clock edge.
    #1 rst = 1'b1;
    #1 chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    run_image("stall", 32'd4, 1'b0, 1);
    rearm();
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_in_ready", 32'(in_ready), 32'd1);

    pay.delete();
    run_image("ovf1025", 32'd1025, 1'b0, 0);
    rearm();
    run_image("ovf_hi", 32'h0001_0000, 1'b0, 0);
    rearm();
    run_image("empty", 32'd0, 1'b0, 0);
    rearm();
    random_pay(CAP);
    run_image("full", 32'(CAP), 1'b0, 0);
    rearm();
`ifdef INSTR_LOADER_CHECKSUM_EN
    pay = '{8'h93, 8'h00, 8'h40, 8'h00};
    run_image("csum_bad", 32'd4, 1'b1, 0);
    rearm();
`endif

    // Abort mid-image with a byte handshaked in the start cycle.
    wq.delete();
    tx = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2};
    send_stream(0);
    in_valid = 1'b1; in_data = 8'hCC; start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_wr_count", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk("abort_wr0", wq[0], 32'h0000_00A1);
      chk("abort_wr1", wq[1], 32'h0000_01B2);
    end
    $display("txn abort writes=%0d done=%0b err=%0b", wq.size(), done, err);
    pay = '{8'h11, 8'h22, 8'h33};
    run_image("after_abort", 32'd3, 1'b0, 0);
    rearm();

    for (int it = 0; it < 12; it++) begin
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        pay.delete();
        n = ($urandom_range(0, 1) == 1) ? 32'(CAP + 1 + $urandom_range(0, 5000))
                                        : ($urandom | 32'h0000_0800);
      end else if (sel == 1) begin
        pay.delete();
        n = 32'd0;
      end else begin
        n = 32'($urandom_range(1, 40));
        random_pay(int'(n));
      end
      run_image($sformatf("rand%0d", it), n, CSUM_EN && ($urandom_range(0, 3) == 0),
                $urandom_range(0, 2));
      rearm();
    end

    chk("never_done_and_err", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader and write-side counterpart of the instruction fetch stage. It accepts a byte stream from a host link, such as a UART receiver, through a valid/ready handshake. Each payload byte is written into the byte-addressed instruction memory, starting at address 0 and running in ascending order. When the image is complete it raises `done`, which releases the core to begin fetching at PC 0.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory byte-address width; capacity is 2^ADDR_WIDTH bytes.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that aborts or re-arms the loader.
- `in_data` input 8: incoming stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a byte.
- `wr_en` output 1: instruction-memory byte write strobe.
- `wr_addr` output ADDR_WIDTH: byte address being written.
- `wr_data` output 8: byte being written.
- `busy` output 1: load in progress; high in `LEN`, `DATA` and `CSUM`.
- `done` output 1: image loaded successfully; held high.
- `err` output 1: load failed; held high.

## Operation
- Stream format, little-endian: a 4-byte length N, then N payload bytes, then one checksum byte (checksum byte only when `CHECKSUM_EN` is defined).
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- States: `LEN`, `DATA`, `CSUM`, `DONE`, `ERR`. Reset enters `LEN`.
- **LEN**
  - Shift accepted bytes into a 32-bit length register, first byte into bits [7:0].
  - After the 4th byte, check N:
    - N > 2^ADDR_WIDTH -> `ERR`.
    - N == 0 -> `CSUM` if enabled, else `DONE`.
    - Otherwise -> `DATA`, with the byte index cleared to 0.
- **DATA**
  - Each accepted byte is written at address = byte index.
  - Byte index increments; its width is ADDR_WIDTH+1 so a full-capacity image does not wrap.
  - After byte N-1 -> `CSUM` if enabled, else `DONE`.
- **CSUM**: one accepted byte is compared with the running XOR of all payload bytes.
  - Match -> `DONE`.
  - Mismatch -> `ERR`.
- **DONE / ERR**
  - `in_ready` = 0; input is ignored.
  - State is held until `start` or `rst`.
- `start` in any state:
  - Next state `LEN`; `done`, `err`, the length register, the byte index and the checksum accumulator are all cleared.
  - A byte presented in the same cycle is discarded, even if the handshake completed.
- `in_ready` is a combinational decode of state: 1 in `LEN`, `DATA` and `CSUM`, 0 otherwise. It does not depend on `start`.
- Length register bits above ADDR_WIDTH are used only for the overflow check.

## Timing
- Reset values:
  - `in_ready` = 1, since the state is `LEN`.
  - `busy` = 1.
  - `wr_en`, `wr_addr`, `wr_data`, `done` and `err` = 0.
  - Internal counters = 0.
- Write latency:
  - `wr_en`, `wr_addr` and `wr_data` are registered and asserted the cycle after the accepting edge.
  - `wr_en` is high for exactly one cycle per payload byte.
  - `wr_addr` and `wr_data` hold their last values while `wr_en` is low.
- Throughput is one byte per cycle in every receiving state; back-to-back `in_valid` is fully supported.
- `done` and `err` rise on the edge that accepts the final byte (or the 4th length byte, for an overflow or empty image).
  - The final payload write (`wr_en`) appears in the same cycle that `done` first reads high.
- `done` and `err` are mutually exclusive and never both high.
- Stalls: `in_valid` low for any number of cycles causes no state change.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - The `CSUM` state and XOR accumulator are present.
  - The stream carries a trailing checksum byte.
  - A mismatch sets `err`.
- Not defined:
  - No `CSUM` state and no accumulator.
  - `DATA` (or `LEN` with N == 0) goes straight to `DONE`.
  - `err` is asserted only on length overflow.

## Test plan
- **Reset** -> `in_ready`=1, `busy`=1, `done`=0, `err`=0, `wr_en`=0.
- **Program load**
  - Stimulus: length 04 00 00 00, then bytes 93 00 40 00, then checksum D3 if enabled.
  - Response: writes (0,93), (1,00), (2,40), (3,00) on consecutive cycles, then `done`=1, `in_ready`=0.
- **Overflow**
  - Stimulus: length 01 04 00 00 (1025) with ADDR_WIDTH=10.
  - Response: `err`=1 after the 4th byte, no `wr_en` pulses.
  - Also: length 00 04 00 00 (1024), with the checksum byte sent when enabled, gives 1024 writes at addresses 0..1023, then `done`.
- **Empty image and stalls**
  - Stimulus: length 0 with checksum 00 if enabled.
  - Response: `done`=1 with no writes.
  - Also: `in_valid` toggled 1/0 every cycle through a 4-byte image must give identical writes to the back-to-back case.
- **Checksum mismatch** (`INSTR_LOADER_CHECKSUM_EN` defined): 4-byte image with checksum FF -> all 4 writes occur, then `err`=1, `done`=0.
- **Abort**
  - Stimulus: `start` pulsed in `DATA` after 2 of 4 bytes, with a valid byte presented in the same cycle.
  - Response: that byte is not written; the next 4 bytes are taken as a new length; `done` and `err` stay cleared.
